// File: rtl/mul_issue_ctrl_if.sv
`default_nettype none
// ------------------------------------------------------------------
// mul_issue_ctrl_if: request/response/multiplier bundle for mul_issue_ctrl
// Revision 1.0
// ------------------------------------------------------------------
interface mul_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               req_valid_i;
  logic               req_ready_o;
  logic [2:0]         req_funct3_i;
  logic [WIDTH-1:0]   req_rs1_i;
  logic [WIDTH-1:0]   req_rs2_i;
  logic [4:0]         req_rd_i;
  logic               flush_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [WIDTH-1:0]   resp_data_o;
  logic [4:0]         resp_rd_o;
  logic               busy_o;
  logic               mul_start_o;
  logic [2:0]         mul_funct3_o;
  logic [WIDTH-1:0]   mul_multiplicand_o;
  logic [WIDTH-1:0]   mul_multiplier_o;
  logic               mul_done_i;
  logic [2*WIDTH-1:0] mul_product_i;

  modport slave (
    input  req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           resp_ready_i, mul_done_i, mul_product_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, busy_o,
           mul_start_o, mul_funct3_o, mul_multiplicand_o, mul_multiplier_o
  );

  modport master (
    output req_valid_i, req_funct3_i, req_rs1_i, req_rs2_i, req_rd_i, flush_i,
           resp_ready_i, mul_done_i, mul_product_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_rd_o, busy_o,
           mul_start_o, mul_funct3_o, mul_multiplicand_o, mul_multiplier_o
  );
endinterface
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// mul_issue_ctrl: M-extension multiply issue controller with a one-entry product cache
// Revision 1.0
// ------------------------------------------------------------------
module mul_issue_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  mul_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [2:0]         op_funct3;
  logic [WIDTH-1:0]   op_rs1, op_rs2;
  logic [4:0]         op_rd;
  logic [WIDTH-1:0]   resp_data;
  logic [2:0]         mul_funct3;
  logic [WIDTH-1:0]   mul_multiplicand, mul_multiplier;
  logic               cache_valid;
  logic [WIDTH-1:0]   cache_rs1, cache_rs2;
  logic [1:0]         cache_cls;
  logic [2*WIDTH-1:0] cache_product;
  logic [1:0]         guard;
  logic               accept, hit, capture, mul_start;

  function automatic logic [1:0] class_of(input logic [1:0] f);
    case (f)
      2'b10:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] select_half(input logic [2:0] f3,
                                                   input logic [2*WIDTH-1:0] p);
    return (f3 == 3'b000) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
  endfunction

  assign bus.req_ready_o = (state == IDLE) && !bus.flush_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;
  assign hit             = cache_valid
                        && (bus.req_rs1_i == cache_rs1)
                        && (bus.req_rs2_i == cache_rs2)
                        && (class_of(bus.req_funct3_i[1:0]) == cache_cls);
  // done is only trusted once the guard has run out; a flush always wins
  assign capture         = (state == WAIT) && !bus.flush_i && (guard == 2'd2) && bus.mul_done_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.req_funct3_i[2] || hit) state_nx = RESP;
          else                            state_nx = LAUNCH;
        end
      end
      LAUNCH: begin
        mul_start = 1'b1;
        state_nx  = bus.flush_i ? IDLE : WAIT;
      end
      WAIT: begin
        if (bus.flush_i)  state_nx = IDLE;
        else if (capture) state_nx = RESP;
      end
      RESP: begin
        if (bus.flush_i || bus.resp_ready_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_funct3        <= '0;
      op_rs1           <= '0;
      op_rs2           <= '0;
      op_rd            <= '0;
      resp_data        <= '0;
      mul_funct3       <= '0;
      mul_multiplicand <= '0;
      mul_multiplier   <= '0;
      cache_valid      <= 1'b0;
      cache_rs1        <= '0;
      cache_rs2        <= '0;
      cache_cls        <= '0;
      cache_product    <= '0;
      guard            <= '0;
    end else begin
      if (accept) begin
        op_funct3 <= bus.req_funct3_i;
        op_rs1    <= bus.req_rs1_i;
        op_rs2    <= bus.req_rs2_i;
        op_rd     <= bus.req_rd_i;
        if (bus.req_funct3_i[2]) begin
          resp_data <= '0;
        end else if (hit) begin
          resp_data <= select_half(bus.req_funct3_i, cache_product);
        end else begin
          // operands stay put through WAIT: the multiplier re-reads them at completion
          mul_funct3       <= bus.req_funct3_i;
          mul_multiplicand <= bus.req_rs1_i;
          mul_multiplier   <= bus.req_rs2_i;
        end
      end

      if (state == LAUNCH)                       guard <= '0;
      else if (state == WAIT && guard != 2'd2)   guard <= guard + 2'd1;

      if (capture) begin
        cache_valid   <= 1'b1;
        cache_product <= bus.mul_product_i;
        cache_rs1     <= op_rs1;
        cache_rs2     <= op_rs2;
        cache_cls     <= class_of(op_funct3[1:0]);
        resp_data     <= select_half(op_funct3, bus.mul_product_i);
      end

      if (bus.flush_i) cache_valid <= 1'b0;
    end
  end

  assign bus.resp_valid_o       = (state == RESP);
  assign bus.resp_data_o        = resp_data;
  assign bus.resp_rd_o          = op_rd;
  assign bus.busy_o             = (state != IDLE);
  assign bus.mul_start_o        = mul_start;
  assign bus.mul_funct3_o       = mul_funct3;
  assign bus.mul_multiplicand_o = mul_multiplicand;
  assign bus.mul_multiplier_o   = mul_multiplier;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_mul_issue_ctrl: randomized self-checking bench with a multiplier model and result reference
// Revision 1.0
// ------------------------------------------------------------------
module tb_mul_issue_ctrl;
  localparam int W = 32;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;
  always #5 clk_i = ~clk_i;

  mul_issue_ctrl_if #(.WIDTH(W)) bus ();

  mul_issue_ctrl #(.WIDTH(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int start_count = 0;
  int mul_lat = 4;
  int mphase, mcnt;

  // reference cache: tracks which (operands, class) the design should remember
  bit          mc_valid = 1'b0;
  logic [31:0] mc_a, mc_b;
  int          mc_cls;

  function automatic int cls_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b10) return 1;
    if (f3[1:0] == 2'b11) return 2;
    return 0;
  endfunction

  function automatic logic [63:0] full_prod(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (f3[1:0])
      2'b10:   return sa * ub;
      2'b11:   return ua * ub;
      default: return sa * sb;
    endcase
  endfunction

  function automatic logic [31:0] exp_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (f3[2]) return 32'h0;
    p = full_prod(f3, a, b);
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk_i)
    if (bus.mul_start_o === 1'b1) start_count <= start_count + 1;

  // multiplier model: done from the previous op lingers 2 cycles past the start pulse
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus.mul_done_i    <= 1'b0;
      bus.mul_product_i <= '0;
      mphase            <= 0;
      mcnt              <= 0;
    end else if (bus.mul_start_o === 1'b1) begin
      mphase <= 1;
      mcnt   <= 1;
    end else if (mphase == 1) begin
      if (mcnt == 0) begin
        bus.mul_done_i <= 1'b0;
        mphase         <= 2;
        mcnt           <= mul_lat;
      end else mcnt <= mcnt - 1;
    end else if (mphase == 2) begin
      if (mcnt == 0) begin
        bus.mul_done_i    <= 1'b1;
        bus.mul_product_i <= full_prod(bus.mul_funct3_o, bus.mul_multiplicand_o, bus.mul_multiplier_o);
        mphase            <= 0;
      end else mcnt <= mcnt - 1;
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output bit ok, output int sc0);
    int n;
    ok = 1'b1;
    @(posedge clk_i); #1;
    bus.req_valid_i  = 1'b1;
    bus.req_funct3_i = f3;
    bus.req_rs1_i    = a;
    bus.req_rs2_i    = b;
    bus.req_rd_i     = rd;
    @(negedge clk_i);
    n = 0;
    while (bus.req_ready_o !== 1'b1 && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: req_ready_o=%b required 1", bus.req_ready_o);
      ok = 1'b0;
    end
    sc0 = start_count;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    bit ok, exp_hit, is_div;
    int sc0, n, exp_starts;
    logic [31:0] exp, d0;
    is_div  = f3[2];
    exp_hit = !is_div && mc_valid && mc_a == a && mc_b == b && mc_cls == cls_of(f3);
    exp     = exp_result(f3, a, b);
    issue(f3, a, b, rd, ok, sc0);
    if (!ok) return;
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (bus.resp_valid_o !== 1'b1 && n < 400);
    checks++;
    if (bus.resp_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL resp_timeout: resp_valid_o=%b required 1", bus.resp_valid_o);
      return;
    end
    checks++;
    if (exp_hit || is_div) begin
      if (n !== 1) begin
        errors++;
        $display("FAIL short_latency: f3=%0d latency=%0d required 1", f3, n);
      end
    end else if (n < 5) begin
      errors++;
      $display("FAIL miss_latency: f3=%0d latency=%0d required >=5", f3, n);
    end
    exp_starts = (exp_hit || is_div) ? 0 : 1;
    checks++;
    if (start_count - sc0 !== exp_starts) begin
      errors++;
      $display("FAIL start_pulses: got %0d required %0d", start_count - sc0, exp_starts);
    end
    checks++;
    if (bus.resp_data_o !== exp) begin
      errors++;
      $display("FAIL resp_data: f3=%0d a=%h b=%h got %h required %h", f3, a, b, bus.resp_data_o, exp);
    end
    checks++;
    if (bus.resp_rd_o !== rd) begin
      errors++;
      $display("FAIL resp_rd: got %0d required %0d", bus.resp_rd_o, rd);
    end
    if (exp_starts == 1) begin
      checks++;
      if (bus.mul_multiplicand_o !== a || bus.mul_multiplier_o !== b || bus.mul_funct3_o !== f3) begin
        errors++;
        $display("FAIL mul_operands: got %h/%h/%0d required %h/%h/%0d",
                 bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.mul_funct3_o, a, b, f3);
      end
    end
    d0 = exp;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      checks++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== d0 || bus.req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold: valid=%b data=%h ready=%b required 1/%h/0",
                 bus.resp_valid_o, bus.resp_data_o, bus.req_ready_o, d0);
      end
    end
    @(posedge clk_i); #1;
    bus.resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.resp_ready_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: valid=%b busy=%b ready=%b required 0/0/1",
               bus.resp_valid_o, bus.busy_o, bus.req_ready_o);
    end
    if (exp_starts == 1) begin
      mc_valid = 1'b1;
      mc_a     = a;
      mc_b     = b;
      mc_cls   = cls_of(f3);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.mul_start_o !== 1'b0 || bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_ctrl: start=%b valid=%b busy=%b required 0/0/0", tag,
               bus.mul_start_o, bus.resp_valid_o, bus.busy_o);
    end
    checks++;
    if (bus.resp_data_o !== '0 || bus.resp_rd_o !== '0 || bus.mul_funct3_o !== '0 ||
        bus.mul_multiplicand_o !== '0 || bus.mul_multiplier_o !== '0) begin
      errors++;
      $display("FAIL %s_data: data=%h rd=%h f3=%h a=%h b=%h required all 0", tag, bus.resp_data_o,
               bus.resp_rd_o, bus.mul_funct3_o, bus.mul_multiplicand_o, bus.mul_multiplier_o);
    end
  endtask

  task automatic test_reset;
    bus.req_valid_i  = 1'b0;
    bus.req_funct3_i = '0;
    bus.req_rs1_i    = '0;
    bus.req_rs2_i    = '0;
    bus.req_rd_i     = '0;
    bus.flush_i      = 1'b0;
    bus.resp_ready_i = 1'b0;
    reset_i          = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_all_zero("reset");
    checks++;
    if (bus.req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b required 1", bus.req_ready_o);
    end
    @(posedge clk_i); #1;
    reset_i  = 1'b0;
    mc_valid = 1'b0;
  endtask

  task automatic test_mul_basic;
    mul_lat = 2 * W;
    do_req(3'b000, 32'd7, 32'hFFFFFFFD, 5'd13, 0);
  endtask

  task automatic test_mulh_variants;
    mul_lat = 10;
    do_req(3'b001, 32'h80000000, 32'h80000000, 5'd1, 1);
    do_req(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0);
    do_req(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, 2);
  endtask

  task automatic test_cache_hit;
    mul_lat = 6;
    do_req(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd4, 0);
    do_req(3'b000, 32'h12345678, 32'h9ABCDEF0, 5'd5, 0);
    do_req(3'b100, 32'h12345678, 32'h9ABCDEF0, 5'd6, 1);
    do_req(3'b001, 32'h12345678, 32'h9ABCDEF0, 5'd7, 0);
    do_req(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd8, 0);
  endtask

  task automatic test_back_to_back_hold;
    mul_lat = 3;
    do_req(3'b000, 32'hDEADBEEF, 32'h00000123, 5'd9, 5);
    do_req(3'b000, 32'hDEADBEEF, 32'h00000123, 5'd10, 5);
  endtask

  task automatic test_flush_wait;
    bit ok, seen;
    int sc0;
    mul_lat = 30;
    issue(3'b001, 32'hCAFEF00D, 32'h00ABCDEF, 5'd11, ok, sc0);
    repeat (10) @(posedge clk_i);
    #1 bus.flush_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bus.busy_o !== 1'b1 || bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_pre: busy=%b valid=%b required 1/0", bus.busy_o, bus.resp_valid_o);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    mc_valid    = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.resp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_wait_idle: busy=%b valid=%b required 0/0", bus.busy_o, bus.resp_valid_o);
    end
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (bus.resp_valid_o !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_wait_noresp: response seen=1 required 0");
    end
    do_req(3'b001, 32'hCAFEF00D, 32'h00ABCDEF, 5'd11, 0);
  endtask

  task automatic test_flush_resp;
    bit ok;
    int sc0;
    issue(3'b110, 32'h1, 32'h2, 5'd12, ok, sc0);
    @(negedge clk_i);
    checks++;
    if (bus.resp_valid_o !== 1'b1 || bus.resp_data_o !== 32'h0) begin
      errors++;
      $display("FAIL div_resp: valid=%b data=%h required 1/0", bus.resp_valid_o, bus.resp_data_o);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    mc_valid    = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_resp: valid=%b busy=%b required 0/0", bus.resp_valid_o, bus.busy_o);
    end
    // the cache was valid before the flush, so this must now miss
    do_req(3'b011, 32'h12345678, 32'h9ABCDEF0, 5'd12, 0);
  endtask

  task automatic test_flush_with_done;
    bit ok;
    int sc0;
    mul_lat = 6;
    issue(3'b000, 32'h0BADF00D, 32'h00000031, 5'd14, ok, sc0);
    repeat (10) @(posedge clk_i);
    #1 bus.flush_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if (bus.mul_done_i !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_align: mul_done_i=%b required 1", bus.mul_done_i);
    end
    @(posedge clk_i); #1;
    bus.flush_i = 1'b0;
    mc_valid    = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_done: valid=%b busy=%b required 0/0", bus.resp_valid_o, bus.busy_o);
    end
    do_req(3'b000, 32'h0BADF00D, 32'h00000031, 5'd14, 0);
  endtask

  task automatic test_stale_done;
    mul_lat = 0;
    do_req(3'b011, 32'h00010000, 32'h00010000, 5'd15, 0);
    do_req(3'b011, 32'hFFFF0000, 32'h00030000, 5'd16, 0);
  endtask

  task automatic test_reset_in_wait;
    bit ok;
    int sc0;
    mul_lat = 30;
    do_req(3'b001, 32'h55555555, 32'h33333333, 5'd17, 0);
    issue(3'b000, 32'h77777777, 32'h99999999, 5'd18, ok, sc0);
    repeat (5) @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1 check_all_zero("reset_wait");
    @(posedge clk_i); #1;
    reset_i  = 1'b0;
    mc_valid = 1'b0;
    @(negedge clk_i);
    checks++;
    if (bus.resp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait_idle: valid=%b busy=%b required 0/0", bus.resp_valid_o, bus.busy_o);
    end
    mul_lat = 5;
    do_req(3'b001, 32'h55555555, 32'h33333333, 5'd17, 0);
  endtask

  task automatic test_random;
    logic [31:0] pool [4];
    logic [31:0] a, b;
    logic [2:0]  f3;
    pool[0] = 32'h0;
    pool[1] = 32'hFFFFFFFF;
    pool[2] = 32'h80000000;
    pool[3] = $urandom;
    a = $urandom;
    b = $urandom;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        a = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
        b = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
      end
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      mul_lat = $urandom_range(0, 20);
      do_req(f3, a, b, 5'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mulh_variants();
    test_cache_hit();
    test_back_to_back_hold();
    test_flush_wait();
    test_flush_resp();
    test_flush_with_done();
    test_stale_done();
    test_reset_in_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
